// File: rtl/full_subtractor_reg_pkg.sv
// Shared constants for the ripple-borrow subtractor.
// Default width gives the classic single-bit full subtractor.
package full_subtractor_reg_pkg;

  localparam int DEF_WIDTH = 1;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout on underflow.
// Chained by the top level to form the ripple-borrow path.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x;

  assign x    = a ^ b;
  assign d    = x ^ bin;
  assign bout = (~a & b) | (~x & bin);

endmodule

// File: rtl/full_subtractor_reg.sv
// Ripple-borrow subtractor a - b - borrow_in with a combinational
// result and a one-cycle registered copy qualified by in_valid.
module full_subtractor_reg
  import full_subtractor_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_out_q,
  output logic             out_valid
);

  logic [WIDTH:0] bw;

  assign bw[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bw[i]),
      .d    (diff[i]),
      .bout (bw[i+1])
    );
  end

  assign borrow_out = bw[WIDTH];

  // Result registers hold while in_valid is low; valid tracks every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q       <= diff;
        borrow_out_q <= borrow_out;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against an
// arithmetic reference model, directed cases plus random vectors.
module tb_full_subtractor_reg;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, bi1, iv1;
  logic       d1, bo1, dq1, boq1, ov1;

  logic [7:0] a8, b8;
  logic       bi8, iv8;
  logic [7:0] d8, dq8;
  logic       bo8, boq8, ov8;

  int n_cmp;
  int n_bad;

  int  m_dq1, m_dq8;
  bit  m_boq1, m_boq8, m_ov1, m_ov8;

  full_subtractor_reg #(.WIDTH(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a1),
    .b            (b1),
    .borrow_in    (bi1),
    .in_valid     (iv1),
    .diff         (d1),
    .borrow_out   (bo1),
    .diff_q       (dq1),
    .borrow_out_q (boq1),
    .out_valid    (ov1)
  );

  full_subtractor_reg #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a8),
    .b            (b8),
    .borrow_in    (bi8),
    .in_valid     (iv8),
    .diff         (d8),
    .borrow_out   (bo8),
    .diff_q       (dq8),
    .borrow_out_q (boq8),
    .out_valid    (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_sub(input int w, input int a, input int b,
                                  input int bin, output int d,
                                  output bit bo);
    int r;
    r  = a - b - bin;
    bo = (r < 0);
    d  = r & ((1 << w) - 1);
  endfunction

  task automatic check_comb();
    int d;
    bit bo;
    ref_sub(1, int'(a1), int'(b1), int'(bi1), d, bo);
    chk("diff1", 32'(d1), 32'(d));
    chk("bout1", 32'(bo1), 32'(bo));
    ref_sub(8, int'(a8), int'(b8), int'(bi8), d, bo);
    chk("diff8", 32'(d8), 32'(d));
    chk("bout8", 32'(bo8), 32'(bo));
  endtask

  task automatic check_regs();
    chk("dq1", 32'(dq1), 32'(m_dq1));
    chk("boq1", 32'(boq1), 32'(m_boq1));
    chk("ov1", 32'(ov1), 32'(m_ov1));
    chk("dq8", 32'(dq8), 32'(m_dq8));
    chk("boq8", 32'(boq8), 32'(m_boq8));
    chk("ov8", 32'(ov8), 32'(m_ov8));
  endtask

  task automatic clear_model();
    m_dq1 = 0; m_boq1 = 0; m_ov1 = 0;
    m_dq8 = 0; m_boq8 = 0; m_ov8 = 0;
  endtask

  // Drive after the falling edge, check comb, clock, then check regs.
  task automatic step(input logic [7:0] av8, input logic [7:0] bv8,
                      input logic bin8, input logic v8,
                      input logic av1, input logic bv1,
                      input logic bin1, input logic v1);
    int d;
    bit bo;
    a8 = av8; b8 = bv8; bi8 = bin8; iv8 = v8;
    a1 = av1; b1 = bv1; bi1 = bin1; iv1 = v1;
    #1;
    check_comb();
    @(posedge clk);
    m_ov1 = v1;
    m_ov8 = v8;
    if (v1) begin
      ref_sub(1, int'(av1), int'(bv1), int'(bin1), d, bo);
      m_dq1 = d; m_boq1 = bo;
    end
    if (v8) begin
      ref_sub(8, int'(av8), int'(bv8), int'(bin8), d, bo);
      m_dq8 = d; m_boq8 = bo;
    end
    #1;
    check_regs();
    @(negedge clk);
  endtask

  logic [1:0] tt [8];
  logic [2:0] seq [5];
  logic [1:0] seq_exp [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_model();
    tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    seq = '{3'b110, 3'b110, 3'b010, 3'b100, 3'b101};
    seq_exp = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00};
    rst_n = 1'b0;
    a1 = 0; b1 = 0; bi1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; bi8 = 0; iv8 = 0;
    #2;
    check_regs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive single-bit truth table against literal values.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bi1 = v[0];
      #1;
      chk("tt_diff", 32'(d1), 32'(tt[i][1]));
      chk("tt_bout", 32'(bo1), 32'(tt[i][0]));
    end

    for (int i = 0; i < 5; i++) begin
      logic [2:0] v;
      v = seq[i];
      step(8'h00, 8'h00, 1'b0, 1'b0, v[2], v[1], v[0], 1'b1);
      chk("seq_dq1", 32'(dq1), 32'(seq_exp[i][1]));
      chk("seq_boq1", 32'(boq1), 32'(seq_exp[i][0]));
    end

    a8 = 8'h00; b8 = 8'h01; bi8 = 1'b0;
    #1;
    chk("w8_zero_minus_one_d", 32'(d8), 32'h0FF);
    chk("w8_zero_minus_one_b", 32'(bo8), 32'h1);
    a8 = 8'h80; b8 = 8'h7F; bi8 = 1'b1;
    #1;
    chk("w8_80_7f_d", 32'(d8), 32'h00);
    chk("w8_80_7f_b", 32'(bo8), 32'h0);
    @(negedge clk);

    step(8'd5, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reg_5_3_1_dq", 32'(dq8), 32'h1);
    chk("reg_5_3_1_ov", 32'(ov8), 32'h1);
    step(8'hAA, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("hold_dq", 32'(dq8), 32'h1);
    chk("hold_ov", 32'(ov8), 32'h0);

    // Mid-operation asynchronous reset between clock edges.
    step(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    a8 = 8'h10; b8 = 8'h20; bi8 = 1'b0; iv8 = 1'b1;
    a1 = 1'b0; b1 = 1'b1; bi1 = 1'b1; iv1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_regs();
    check_comb();
    chk("rst_comb_d8", 32'(d8), 32'h0F0);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1200; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
